// File: rtl/slice_cfg_loader.sv
// -----------------------------------------------------------------------------
// slice_cfg_loader
//
// Writer side of the logic-slice LUT configuration interface. Collects
// byte-wide configuration frames from a host over a valid/ready stream and
// serially shifts the two LUT INIT values of each frame, MSB first, into the
// configuration chain of the addressed slice.
//
// Frame: byte0 = slice address, byte1 = LUT1 INIT, byte2 = LUT2 INIT,
//        byte3 = parity (byte0 ^ byte1 ^ byte2) when SLICE_CFG_PARITY_EN is
//        defined. Without the macro frames are three bytes and only an
//        out-of-range address rejects a frame.
//
// Parameters:
//   NUM_SLICES  number of addressable slices (legal addresses 0..NUM_SLICES-1)
//   LUT_BITS    INIT width per LUT (<= 8, taken from the low bits of a byte)
//
// Ports:
//   CLK       rising-edge clock
//   RST       asynchronous, active-high reset
//   in_data   frame byte from the host
//   in_valid  in_data is valid
//   in_ready  a byte is accepted this cycle (decoded from state, 0 in reset)
//   cfg_sdo   serial configuration bit to the slice chains
//   cfg_en    shift enable for the selected chain
//   cfg_sel   one-hot slice select, valid while cfg_en=1
//   busy      frame in progress (any state other than WAIT_ADDR)
//   done      one-cycle pulse after the last bit has been shifted
//   err       one-cycle pulse on a rejected frame
// -----------------------------------------------------------------------------
module slice_cfg_loader #(
   parameter int NUM_SLICES = 4,
   parameter int LUT_BITS   = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  cfg_sdo,
   output logic                  cfg_en,
   output logic [NUM_SLICES-1:0] cfg_sel,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int                WORD_BITS = 2 * LUT_BITS;
   localparam int                CNT_W     = $clog2(WORD_BITS);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_BITS - 1);

   typedef enum logic [2:0] {
      WAIT_ADDR,
      GET_L1,
      GET_L2,
`ifdef SLICE_CFG_PARITY_EN
      GET_PAR,
`endif
      SHIFT,
      FINISH
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              addr_q, addr_d;
   logic                    bad_q, bad_d;
   logic [7:0]              lut1_q, lut1_d;
`ifdef SLICE_CFG_PARITY_EN
   logic [7:0]              lut2_q, lut2_d;
`endif
   logic [WORD_BITS-1:0]    sr_q, sr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    cfg_en_q, cfg_en_d;
   logic [NUM_SLICES-1:0]   cfg_sel_q, cfg_sel_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   logic                    accept_state;
   logic                    xfer;
   logic                    frame_end;
   logic                    frame_ok;
   logic [WORD_BITS-1:0]    load_word;
   logic [NUM_SLICES-1:0]   sel_dec;

   // in_ready is the only unregistered output; gating with RST keeps it low
   // while the state register is held in WAIT_ADDR by reset.
   always_comb begin
      accept_state = (state_q == WAIT_ADDR) || (state_q == GET_L1) || (state_q == GET_L2);
`ifdef SLICE_CFG_PARITY_EN
      accept_state = accept_state || (state_q == GET_PAR);
`endif
   end

   assign in_ready = accept_state && !RST;
   assign xfer     = in_valid && in_ready;

   always_comb begin
      sel_dec = '0;
      for (int i = 0; i < NUM_SLICES; i++) begin
         sel_dec[i] = (int'(addr_q) == i);
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d   = state_q;
      addr_d    = addr_q;
      bad_d     = bad_q;
      lut1_d    = lut1_q;
`ifdef SLICE_CFG_PARITY_EN
      lut2_d    = lut2_q;
`endif
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      cfg_en_d  = cfg_en_q;
      cfg_sel_d = cfg_sel_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      frame_end = 1'b0;
      frame_ok  = 1'b0;
      load_word = '0;

      case (state_q)
         WAIT_ADDR: begin
            if (xfer) begin
               // A bad address is only flagged here; the rest of the frame is
               // still consumed so the host's byte stream stays aligned.
               addr_d  = in_data;
               bad_d   = (int'(in_data) >= NUM_SLICES);
               state_d = GET_L1;
            end
         end
         GET_L1: begin
            if (xfer) begin
               lut1_d  = in_data;
               state_d = GET_L2;
            end
         end
         GET_L2: begin
            if (xfer) begin
`ifdef SLICE_CFG_PARITY_EN
               lut2_d  = in_data;
               state_d = GET_PAR;
`else
               frame_end = 1'b1;
               frame_ok  = !bad_q;
               load_word = {lut1_q[LUT_BITS-1:0], in_data[LUT_BITS-1:0]};
`endif
            end
         end
`ifdef SLICE_CFG_PARITY_EN
         GET_PAR: begin
            if (xfer) begin
               frame_end = 1'b1;
               frame_ok  = !bad_q && (in_data == (addr_q ^ lut1_q ^ lut2_q));
               load_word = {lut1_q[LUT_BITS-1:0], lut2_q[LUT_BITS-1:0]};
            end
         end
`endif
         SHIFT: begin
            // Zero fill leaves the register cleared once all bits are out, so
            // cfg_sdo idles low between frames.
            sr_d = sr_q << 1;
            if (cnt_q == LAST_BIT) begin
               state_d   = FINISH;
               cfg_en_d  = 1'b0;
               cfg_sel_d = '0;
               done_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FINISH: begin
            state_d = WAIT_ADDR;
         end
         default: begin
            state_d = WAIT_ADDR;
         end
      endcase

      // Check step, taken on the edge that accepts the last frame byte: a
      // good frame presents its first bit in the very next cycle.
      if (frame_end) begin
         if (frame_ok) begin
            state_d   = SHIFT;
            sr_d      = load_word;
            cnt_d     = '0;
            cfg_en_d  = 1'b1;
            cfg_sel_d = sel_dec;
         end else begin
            state_d = FINISH;
            err_d   = 1'b1;
         end
      end

      busy_d = (state_d != WAIT_ADDR);
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= WAIT_ADDR;
         addr_q    <= '0;
         bad_q     <= 1'b0;
         lut1_q    <= '0;
`ifdef SLICE_CFG_PARITY_EN
         lut2_q    <= '0;
`endif
         sr_q      <= '0;
         cnt_q     <= '0;
         cfg_en_q  <= 1'b0;
         cfg_sel_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         bad_q     <= bad_d;
         lut1_q    <= lut1_d;
`ifdef SLICE_CFG_PARITY_EN
         lut2_q    <= lut2_d;
`endif
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         cfg_en_q  <= cfg_en_d;
         cfg_sel_q <= cfg_sel_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign cfg_sdo = sr_q[WORD_BITS-1];
   assign cfg_en  = cfg_en_q;
   assign cfg_sel = cfg_sel_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_slice_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_slice_cfg_loader
//
// Bench for slice_cfg_loader. Drives frames through the byte stream, records
// what the configuration side does after the last byte, and compares that with
// the outcome derived from the frame contents.
// -----------------------------------------------------------------------------
module tb_slice_cfg_loader;

   localparam int NUM_SLICES = 4;
   localparam int LUT_BITS   = 8;
   localparam int TIMEOUT    = 64;

   logic                  CLK = 1'b0;
   logic                  RST;
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  cfg_sdo;
   logic                  cfg_en;
   logic [NUM_SLICES-1:0] cfg_sel;
   logic                  busy;
   logic                  done;
   logic                  err;

   int checks   = 0;
   int failures = 0;

   // What happened from the cycle after the last frame byte until in_ready
   // came back. Offsets are in cycles from that first cycle; 8'hFF = never.
   typedef struct packed {
      logic [15:0]           bits;
      logic [7:0]            en_cnt;
      logic [7:0]            en_first;
      logic [NUM_SLICES-1:0] sel;
      logic [7:0]            stray_sel;
      logic [7:0]            done_cnt;
      logic [7:0]            done_off;
      logic [7:0]            err_cnt;
      logic [7:0]            err_off;
      logic [7:0]            busy_err;
      logic [7:0]            ready_off;
   } obs_t;

   slice_cfg_loader #(
      .NUM_SLICES (NUM_SLICES),
      .LUT_BITS   (LUT_BITS)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .cfg_sdo  (cfg_sdo),
      .cfg_en   (cfg_en),
      .cfg_sel  (cfg_sel),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // Expected outcome of a frame, derived from the frame rules.
   function automatic obs_t model(input logic [7:0] a, input logic [7:0] b1,
                                  input logic [7:0] b2, input logic [7:0] p);
      obs_t e;
      logic bad;
      e           = '0;
      e.en_first  = 8'hFF;
      e.done_off  = 8'hFF;
      e.err_off   = 8'hFF;
      bad = (int'(a) >= NUM_SLICES);
`ifdef SLICE_CFG_PARITY_EN
      bad = bad || (p != (a ^ b1 ^ b2));
`else
      if (p === 8'hxx) bad = 1'b1;
`endif
      if (bad) begin
         e.err_cnt   = 8'd1;
         e.err_off   = 8'd0;
         e.ready_off = 8'd1;
      end else begin
         for (int i = 7; i >= 0; i--) e.bits = {e.bits[14:0], b1[i]};
         for (int i = 7; i >= 0; i--) e.bits = {e.bits[14:0], b2[i]};
         e.en_cnt    = 8'd16;
         e.en_first  = 8'd0;
         e.sel       = NUM_SLICES'(1) << a;
         e.done_cnt  = 8'd1;
         e.done_off  = 8'd16;
         e.ready_off = 8'd17;
      end
      return e;
   endfunction

   // Present one byte and wait (bounded) for it to be taken. gap = cycles of
   // in_valid low before the byte. Returns on the falling edge after the
   // accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      logic rdy;
      bit   ok;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(negedge CLK);
      end
      in_data  = b;
      in_valid = 1'b1;
      ok       = 1'b0;
      for (int t = 0; t < TIMEOUT && !ok; t++) begin
         rdy = in_ready;
         @(posedge CLK);
         if (rdy) ok = 1'b1;
         @(negedge CLK);
      end
      in_valid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL byte_accept: byte %h not accepted within %0d cycles", b, TIMEOUT);
      end
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] p, input int gap);
      send_byte(a, gap);
      send_byte(b1, gap);
      send_byte(b2, gap);
`ifdef SLICE_CFG_PARITY_EN
      send_byte(p, gap);
`endif
   endtask

   // Records outputs on falling edges starting in the cycle after the last
   // byte, until in_ready returns. Does not touch the inputs.
   task automatic observe(output obs_t o);
      o           = '0;
      o.en_first  = 8'hFF;
      o.done_off  = 8'hFF;
      o.err_off   = 8'hFF;
      o.ready_off = 8'hFF;
      for (int off = 0; off < 40; off++) begin
         if (cfg_en === 1'b1) begin
            if (o.en_first == 8'hFF) o.en_first = 8'(off);
            o.en_cnt = o.en_cnt + 8'd1;
            o.bits   = {o.bits[14:0], cfg_sdo};
            o.sel    = o.sel | cfg_sel;
         end else if (cfg_sel !== '0) begin
            o.stray_sel = o.stray_sel + 8'd1;
         end
         if (done === 1'b1) begin
            o.done_cnt = o.done_cnt + 8'd1;
            o.done_off = 8'(off);
         end
         if (err === 1'b1) begin
            o.err_cnt = o.err_cnt + 8'd1;
            o.err_off = 8'(off);
         end
         if (in_ready === 1'b1) begin
            if (busy !== 1'b0) o.busy_err = o.busy_err + 8'd1;
            o.ready_off = 8'(off);
            break;
         end else if (busy !== 1'b1) begin
            o.busy_err = o.busy_err + 8'd1;
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_reset;
      RST      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(negedge CLK);
      checks++;
      if ({in_ready, cfg_sdo, cfg_en, cfg_sel, busy, done, err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got rdy=%b sdo=%b en=%b sel=%b busy=%b done=%b err=%b, need all 0",
                  in_ready, cfg_sdo, cfg_en, cfg_sel, busy, done, err);
      end
      RST = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got rdy=%b busy=%b, need rdy=1 busy=0", in_ready, busy);
      end
      @(negedge CLK);
   endtask

   task automatic test_basic_frame;
      obs_t o, e;
      send_frame(8'h01, 8'hA5, 8'h3C, 8'h98, 0);
      observe(o);
      e = model(8'h01, 8'hA5, 8'h3C, 8'h98);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL basic_frame: got %p need %p", o, e);
      end
      checks++;
      if (o.bits !== 16'b1010_0101_0011_1100 || o.sel !== 4'b0010) begin
         failures++;
         $display("FAIL basic_bits: got bits=%b sel=%b, need 1010010100111100 sel=0010", o.bits, o.sel);
      end
   endtask

   task automatic test_bad_address;
      obs_t o, e;
      send_frame(8'h07, 8'h12, 8'h34, 8'h07 ^ 8'h12 ^ 8'h34, 0);
      observe(o);
      e = model(8'h07, 8'h12, 8'h34, 8'h07 ^ 8'h12 ^ 8'h34);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL bad_address: got %p need %p", o, e);
      end
      send_frame(8'h03, 8'h81, 8'h7E, 8'h03 ^ 8'h81 ^ 8'h7E, 0);
      observe(o);
      e = model(8'h03, 8'h81, 8'h7E, 8'h03 ^ 8'h81 ^ 8'h7E);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL after_bad_address: got %p need %p", o, e);
      end
   endtask

`ifdef SLICE_CFG_PARITY_EN
   task automatic test_parity;
      obs_t o, e;
      send_frame(8'h00, 8'hFF, 8'h00, 8'h00, 0);
      observe(o);
      e = model(8'h00, 8'hFF, 8'h00, 8'h00);
      checks++;
      if (o !== e || o.err_cnt !== 8'd1 || o.en_cnt !== 8'd0) begin
         failures++;
         $display("FAIL parity_bad: got %p need %p", o, e);
      end
      send_frame(8'h00, 8'hFF, 8'h00, 8'hFF, 0);
      observe(o);
      e = model(8'h00, 8'hFF, 8'h00, 8'hFF);
      checks++;
      if (o !== e || o.en_cnt !== 8'd16) begin
         failures++;
         $display("FAIL parity_good: got %p need %p", o, e);
      end
   endtask
`endif

   task automatic test_valid_toggle;
      obs_t o, e;
      send_frame(8'h02, 8'h5A, 8'hC3, 8'h02 ^ 8'h5A ^ 8'hC3, 2);
      observe(o);
      e = model(8'h02, 8'h5A, 8'hC3, 8'h02 ^ 8'h5A ^ 8'hC3);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL valid_toggle: got %p need %p", o, e);
      end
   endtask

   task automatic test_reset_mid_shift;
      obs_t o, e;
      send_frame(8'h01, 8'hFF, 8'h00, 8'h01 ^ 8'hFF, 0);
      repeat (7) @(negedge CLK);
      checks++;
      if (cfg_en !== 1'b1 || cfg_sdo !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_shift_bit7: got en=%b sdo=%b busy=%b, need 1 1 1", cfg_en, cfg_sdo, busy);
      end
      RST = 1'b1;
      #1;
      checks++;
      if ({cfg_en, cfg_sel, busy, in_ready} !== '0) begin
         failures++;
         $display("FAIL reset_async: got en=%b sel=%b busy=%b rdy=%b, need all 0", cfg_en, cfg_sel, busy, in_ready);
      end
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_release: got rdy=%b need 1", in_ready);
      end
      send_frame(8'h02, 8'h0F, 8'hF0, 8'h02 ^ 8'h0F ^ 8'hF0, 0);
      observe(o);
      e = model(8'h02, 8'h0F, 8'hF0, 8'h02 ^ 8'h0F ^ 8'hF0);
      checks++;
      if (o !== e || o.bits !== 16'b0000_1111_1111_0000) begin
         failures++;
         $display("FAIL reload_after_reset: got %p need %p", o, e);
      end
   endtask

   task automatic test_back_to_back;
      obs_t o, e;
      send_frame(8'h00, 8'h11, 8'h22, 8'h33, 0);
      // Next address is offered immediately and held during the shift.
      in_data  = 8'h03;
      in_valid = 1'b1;
      observe(o);
      e = model(8'h00, 8'h11, 8'h22, 8'h33);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL b2b_first: got %p need %p", o, e);
      end
      send_byte(8'h03, 0);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_addr_taken: got busy=%b need 1", busy);
      end
      send_byte(8'hC0, 0);
      send_byte(8'hFF, 0);
`ifdef SLICE_CFG_PARITY_EN
      send_byte(8'h03 ^ 8'hC0 ^ 8'hFF, 0);
`endif
      observe(o);
      e = model(8'h03, 8'hC0, 8'hFF, 8'h03 ^ 8'hC0 ^ 8'hFF);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL b2b_second: got %p need %p", o, e);
      end
   endtask

   task automatic test_random;
      obs_t o, e;
      logic [7:0] a, b1, b2, p;
      int gap;
      for (int n = 0; n < 10; n++) begin
         a   = 8'($urandom_range(0, 7));
         b1  = 8'($urandom);
         b2  = 8'($urandom);
         p   = a ^ b1 ^ b2;
         if ($urandom_range(0, 3) == 0) p = p ^ 8'h40;
         gap = $urandom_range(0, 2);
         send_frame(a, b1, b2, p, gap);
         observe(o);
         e = model(a, b1, b2, p);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL random_%0d: frame %h %h %h %h got %p need %p", n, a, b1, b2, p, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_bad_address();
`ifdef SLICE_CFG_PARITY_EN
      test_parity();
`endif
      test_valid_toggle();
      test_reset_mid_shift();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
